// File: rtl/rv32_writeback_if.sv
// ---------------------------------------------------------------------------
// rv32_writeback_if : memory-stage to writeback-stage bundle, plus the
//                     register-file and retire-counter outputs.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rv32_writeback_if;
  logic        stall_in;
  logic        flush_in;
  logic        valid_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] result_in;
  logic        load_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  addr_low_in;
  logic [31:0] mem_rdata_in;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        writeback_flush_out;
  logic [63:0] instret_out;

  modport master (
    output stall_in, flush_in, valid_in, rd_in, rd_write_in, result_in,
           load_in, load_size_in, load_unsigned_in, addr_low_in, mem_rdata_in,
    input  rd_out, rd_write_out, rd_value_out, writeback_flush_out, instret_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, rd_in, rd_write_in, result_in,
           load_in, load_size_in, load_unsigned_in, addr_low_in, mem_rdata_in,
    output rd_out, rd_write_out, rd_value_out, writeback_flush_out, instret_out
  );
endinterface

`default_nettype wire

// File: rtl/rv32_writeback.sv
// ---------------------------------------------------------------------------
// rv32_writeback : RV32 writeback stage with load alignment/extension and a
//                  64-bit retired-instruction counter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32_writeback #(
  parameter int INSTRET_EN = 1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  rv32_writeback_if.slave    wb
);

  logic        valid_q;
  logic [4:0]  rd_q;
  logic        rd_write_q;
  logic [31:0] result_q;
  logic        load_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_q;
  logic [31:0] rdata_q;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;

  // Payload fields capture even for invalid slots; only valid_q gates effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      rd_write_q <= 1'b0;
      result_q   <= 32'd0;
      load_q     <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= 2'd0;
      rdata_q    <= 32'd0;
    end else if (!wb.stall_in) begin
      valid_q    <= wb.valid_in & ~wb.flush_in;
      rd_q       <= wb.rd_in;
      rd_write_q <= wb.rd_write_in;
      result_q   <= wb.result_in;
      load_q     <= wb.load_in;
      size_q     <= wb.load_size_in;
      unsigned_q <= wb.load_unsigned_in;
      addr_q     <= wb.addr_low_in;
      rdata_q    <= wb.mem_rdata_in;
    end
  end

  always_comb begin
    byte_lane = rdata_q[7:0];
    case (addr_q)
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
  end

  // Misaligned halfword addresses are not trapped here; bit 0 is simply dropped.
  assign half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_value = rdata_q;
    case (size_q)
      2'b00:   load_value = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_value = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_value = rdata_q;
    endcase
  end

  assign wb.rd_out              = rd_q;
  assign wb.rd_write_out        = valid_q & rd_write_q & (rd_q != 5'd0);
  assign wb.writeback_flush_out = ~valid_q;
  assign wb.rd_value_out        = load_q ? load_value : result_q;

  generate
    if (INSTRET_EN != 0) begin : g_instret
      logic [63:0] instret_q;

      // Counting on the edge that releases the slot keeps a stalled
      // instruction from being counted more than once.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          instret_q <= 64'd0;
        end else if (valid_q && !wb.stall_in) begin
          instret_q <= instret_q + 64'd1;
        end
      end

      assign wb.instret_out = instret_q;
    end else begin : g_no_instret
      assign wb.instret_out = 64'd0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rv32_writeback.sv
// ---------------------------------------------------------------------------
// tb_rv32_writeback : directed vector table plus stall, wrap and async-reset
//                     sequences for rv32_writeback.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rv32_writeback;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] result;
    logic        load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        exp_rw;
    logic [31:0] exp_val;
  } vec_t;

  localparam int NVEC = 15;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  vec_t vecs [NVEC];

  rv32_writeback_if wb ();

  rv32_writeback #(.INSTRET_EN(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic [4:0] rd,
                              input logic rw, input logic [31:0] res, input logic ld,
                              input logic [1:0] sz, input logic u, input logic [1:0] a,
                              input logic [31:0] rdata, input logic erw,
                              input logic [31:0] eval);
    vec_t t;
    t.valid = v; t.flush = f; t.rd = rd; t.rd_write = rw; t.result = res;
    t.load = ld; t.size = sz; t.uns = u; t.addr = a; t.rdata = rdata;
    t.exp_rw = erw; t.exp_val = eval;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    wb.valid_in         = t.valid;
    wb.flush_in         = t.flush;
    wb.rd_in            = t.rd;
    wb.rd_write_in      = t.rd_write;
    wb.result_in        = t.result;
    wb.load_in          = t.load;
    wb.load_size_in     = t.size;
    wb.load_unsigned_in = t.uns;
    wb.addr_low_in      = t.addr;
    wb.mem_rdata_in     = t.rdata;
  endtask

  task automatic idle();
    drive(mk(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0));
  endtask

  initial begin
    logic [63:0] exp_cnt;
    logic [63:0] c0;
    vec_t        a;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    wb.stall_in = 1'b0;
    idle();

    vecs[0]  = mk(1, 0, 5'd5,  1, 32'h12345678, 0, 2'd0, 0, 2'd0, 32'h0,        1, 32'h12345678);
    vecs[1]  = mk(1, 0, 5'd1,  1, 32'h0,        1, 2'd0, 0, 2'd3, 32'h80FF7F01, 1, 32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 5'd2,  1, 32'h0,        1, 2'd0, 1, 2'd3, 32'h80FF7F01, 1, 32'h00000080);
    vecs[3]  = mk(1, 0, 5'd3,  1, 32'h0,        1, 2'd1, 0, 2'd2, 32'h80FF7F01, 1, 32'hFFFF80FF);
    vecs[4]  = mk(1, 0, 5'd4,  1, 32'h0,        1, 2'd1, 1, 2'd0, 32'h80FF7F01, 1, 32'h00007F01);
    vecs[5]  = mk(1, 0, 5'd6,  1, 32'h0,        1, 2'd2, 0, 2'd0, 32'h80FF7F01, 1, 32'h80FF7F01);
    vecs[6]  = mk(1, 0, 5'd7,  1, 32'h0,        1, 2'd3, 1, 2'd1, 32'h80FF7F01, 1, 32'h80FF7F01);
    vecs[7]  = mk(1, 0, 5'd8,  1, 32'h0,        1, 2'd0, 0, 2'd1, 32'h80FF7F01, 1, 32'h0000007F);
    vecs[8]  = mk(1, 0, 5'd9,  1, 32'h0,        1, 2'd1, 0, 2'd3, 32'h80FF7F01, 1, 32'hFFFF80FF);
    vecs[9]  = mk(1, 0, 5'd13, 1, 32'h0,        1, 2'd0, 0, 2'd2, 32'h80FF7F01, 1, 32'hFFFFFFFF);
    vecs[10] = mk(1, 0, 5'd14, 1, 32'h0,        1, 2'd0, 0, 2'd0, 32'h80FF7F01, 1, 32'h00000001);
    vecs[11] = mk(1, 1, 5'd10, 1, 32'hAAAA5555, 0, 2'd0, 0, 2'd0, 32'h0,        0, 32'hAAAA5555);
    vecs[12] = mk(1, 0, 5'd0,  1, 32'h00000001, 0, 2'd0, 0, 2'd0, 32'h0,        0, 32'h00000001);
    vecs[13] = mk(0, 0, 5'd11, 1, 32'h0BADF00D, 0, 2'd0, 0, 2'd0, 32'h0,        0, 32'h0BADF00D);
    vecs[14] = mk(1, 0, 5'd12, 0, 32'h0000CAFE, 0, 2'd0, 0, 2'd0, 32'h0,        0, 32'h0000CAFE);

    // Reset state
    @(negedge clk);
    chk("reset_rw",    {63'd0, wb.rd_write_out},        64'd0);
    chk("reset_wbf",   {63'd0, wb.writeback_flush_out}, 64'd1);
    chk("reset_val",   {32'd0, wb.rd_value_out},        64'd0);
    chk("reset_inst",  wb.instret_out,                  64'd0);
    reset_n = 1'b1;

    // Vector table: instret at check time counts live vectors before this one
    exp_cnt = 64'd0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_rd", i),   {59'd0, wb.rd_out},                 {59'd0, vecs[i].rd});
      chk($sformatf("v%0d_rw", i),   {63'd0, wb.rd_write_out},           {63'd0, vecs[i].exp_rw});
      chk($sformatf("v%0d_val", i),  {32'd0, wb.rd_value_out},           {32'd0, vecs[i].exp_val});
      chk($sformatf("v%0d_wbf", i),  {63'd0, wb.writeback_flush_out},
          {63'd0, ~(vecs[i].valid & ~vecs[i].flush)});
      chk($sformatf("v%0d_inst", i), wb.instret_out, exp_cnt);
      if (vecs[i].valid && !vecs[i].flush) exp_cnt = exp_cnt + 64'd1;
    end
    idle();
    @(negedge clk);
    chk("table_final_inst", wb.instret_out, exp_cnt);

    // Stall: held instruction counted exactly once, after release
    a = mk(1, 0, 5'd9, 1, 32'h11111111, 0, 2'd0, 0, 2'd0, 32'h0, 1, 32'h11111111);
    drive(a);
    @(negedge clk);
    c0 = wb.instret_out;
    chk("stall_pre_inst", c0, exp_cnt);
    wb.stall_in = 1'b1;
    drive(mk(1, 1, 5'd3, 1, 32'h22222222, 1, 2'd0, 1, 2'd1, 32'hFFFFFFFF, 0, 32'h0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_rd", k),   {59'd0, wb.rd_out},        64'd9);
      chk($sformatf("stall%0d_rw", k),   {63'd0, wb.rd_write_out},  64'd1);
      chk($sformatf("stall%0d_val", k),  {32'd0, wb.rd_value_out},  64'h11111111);
      chk($sformatf("stall%0d_inst", k), wb.instret_out,            c0);
    end
    wb.stall_in = 1'b0;
    idle();
    @(negedge clk);
    chk("stall_rel_inst", wb.instret_out, c0 + 64'd1);
    chk("stall_rel_wbf",  {63'd0, wb.writeback_flush_out}, 64'd1);
    @(negedge clk);
    chk("stall_after_inst", wb.instret_out, c0 + 64'd1);

    // Counter wrap
    drive(a);
    @(negedge clk);
    force dut.g_instret.instret_q = 64'hFFFFFFFFFFFFFFFF;
    #1;
    release dut.g_instret.instret_q;
    #1;
    chk("wrap_forced", wb.instret_out, 64'hFFFFFFFFFFFFFFFF);
    idle();
    @(negedge clk);
    chk("wrap_zero", wb.instret_out, 64'd0);

    // Async reset while stalled with a valid instruction held
    drive(a);
    @(negedge clk);
    chk("rst_pre_rw", {63'd0, wb.rd_write_out}, 64'd1);
    wb.stall_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_rw",   {63'd0, wb.rd_write_out},        64'd0);
    chk("rst_async_wbf",  {63'd0, wb.writeback_flush_out}, 64'd1);
    chk("rst_async_val",  {32'd0, wb.rd_value_out},        64'd0);
    chk("rst_async_inst", wb.instret_out,                  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wb.stall_in = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    chk("rst_resume_val",  {32'd0, wb.rd_value_out}, 64'h12345678);
    chk("rst_resume_rw",   {63'd0, wb.rd_write_out}, 64'd1);
    chk("rst_resume_inst", wb.instret_out,           64'd0);
    idle();
    @(negedge clk);
    chk("rst_retire_inst", wb.instret_out, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv32_writeback.md
RV32_WRITEBACK -- requirements
Module: rv32_writeback

Interface
REQ-001 Parameter: INSTRET_EN, default 1, meaning 1 = retired-instruction counter enabled; 0 = instret_out tied to 0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 stall_in  input  1  hold stage contents; no capture, no retire count.
REQ-005 flush_in  input  1  kill the instruction being captured this cycle.
REQ-006 valid_in  input  1  upstream (memory stage) presents a valid instruction.
REQ-007 rd_in  input  5  destination register index.
REQ-008 rd_write_in  input  1  instruction writes rd.
REQ-009 result_in  input  32  ALU/CSR/link result.
REQ-010 load_in  input  1  instruction is a load; take value from mem_rdata_in.
REQ-011 load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
REQ-013 addr_low_in  input  2  load address bits [1:0].
REQ-014 mem_rdata_in  input  32  raw aligned data word from the data bus.
REQ-015 rd_out  output  5  register index to the register file.
REQ-016 rd_write_out  output  1  register-file write request.
REQ-017 rd_value_out  output  32  value to write; also the forwarding value.
REQ-018 writeback_flush_out  output  1  suppresses the register-file write when the stage is empty.
REQ-019 instret_out  output  64  count of retired instructions.

Function
REQ-020 Stage registers (valid_q, rd_q, rd_write_q, result_q, load_q, size_q, unsigned_q, addr_q, rdata_q) SHALL capture their inputs on posedge clk when stall_in=0.
REQ-021 With stall_in=0: valid_q <= valid_in & ~flush_in; other fields SHALL capture regardless of valid.
REQ-022 With stall_in=1: every stage register SHALL hold; flush_in is ignored.
REQ-023 Latency: inputs SHALL appear on the outputs exactly one cycle after capture; outputs are combinational from the stage registers only.
REQ-024 rd_out = rd_q; rd_write_out = valid_q & rd_write_q & (rd_q != 0).
REQ-025 writeback_flush_out = ~valid_q.
REQ-026 rd_value_out = result_q when load_q=0, else the aligned load value (REQ-027..029).
REQ-027 Byte: lane = rdata_q[8*addr_q+7 : 8*addr_q]; extended to 32 bits per unsigned_q.
REQ-028 Half: lane = rdata_q[31:16] if addr_q[1]=1, else rdata_q[15:0]; addr_q[0] is ignored (no misalign trap here); extended per unsigned_q.
REQ-029 Word or size 11: value = rdata_q; addr_q and unsigned_q ignored.
REQ-030 Retire: when INSTRET_EN=1, instret_out SHALL increment by 1 on each posedge where valid_q=1 and stall_in=0; it wraps from 2^64-1 to 0.
REQ-031 An instruction held for N stalled cycles SHALL be counted once; repeated rd_write_out during stall is permitted (idempotent write).
REQ-032 A flushed or invalid instruction SHALL never assert rd_write_out and SHALL never be counted.
REQ-033 rd_write_in=1 with rd_in=0 SHALL retire (counted) without asserting rd_write_out.

Reset
REQ-034 When reset_n=0, all stage registers and instret_out SHALL clear to 0 asynchronously; therefore rd_write_out=0, writeback_flush_out=1, rd_value_out=0.
REQ-035 Reset asserted mid-stall or mid-instruction SHALL discard the held instruction with no retire count; on the first edge after release, normal capture resumes.

Verification
REQ-036 ALU: valid_in=1, rd_in=5, rd_write_in=1, result_in=0x12345678, load_in=0 -> next cycle rd_write_out=1, rd_out=5, rd_value_out=0x12345678, writeback_flush_out=0; instret_out=1 one edge later.
REQ-037 Loads with mem_rdata_in=0x80FF7F01: lb addr 3 -> 0xFFFFFF80; lbu addr 3 -> 0x00000080; lh addr 2 -> 0xFFFF80FF; lhu addr 0 -> 0x00007F01; lw -> 0x80FF7F01.
REQ-038 Flush: valid_in=1, flush_in=1 -> next cycle rd_write_out=0, writeback_flush_out=1, instret_out unchanged.
REQ-039 Stall: capture an instruction, then hold stall_in=1 for 3 cycles while inputs change -> outputs constant for all 3 cycles; instret_out increments by exactly 1, after stall release.
REQ-040 x0 and wrap: rd_in=0 with rd_write_in=1 -> rd_write_out=0 and instret_out+1; with instret forced to 0xFFFFFFFFFFFFFFFF, one retire -> 0.
REQ-041 Reset: assert reset_n=0 asynchronously between edges while valid_q=1 -> rd_write_out=0 and instret_out=0 immediately, with no clock edge required.
